// File: rtl/sirv_uarttx_arb_if.sv
// Handshake bundle between producer ports, the UART TX arbiter and the transmitter byte input.
// master = producer/transmitter side, slave = arbiter side.
interface sirv_uarttx_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GW    = $clog2(N_REQ),
  parameter int unsigned TMO_W = 8
);
  logic                 en;
  logic [TMO_W-1:0]     tmo_cycles;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_bits;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ-1:0]     req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_bits;
  logic                 tx_ready;
  logic                 locked;
  logic [GW-1:0]        grant_id;
  logic                 tmo_err;

  modport master (
    output en, tmo_cycles, req_valid, req_bits, req_last, tx_ready,
    input  req_ready, tx_valid, tx_bits, locked, grant_id, tmo_err
  );

  modport slave (
    input  en, tmo_cycles, req_valid, req_bits, req_last, tx_ready,
    output req_ready, tx_valid, tx_bits, locked, grant_id, tmo_err
  );
endinterface

// File: rtl/sirv_uarttx_arb.sv
// Round-robin, message-locking arbiter sharing one UART TX byte path between N_REQ producers.
// The owner keeps the transmitter until its last byte; a watchdog releases a stalled owner.
module sirv_uarttx_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GW    = $clog2(N_REQ),
  parameter int unsigned TMO_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  sirv_uarttx_arb_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_bits_q, tx_bits_d;
  logic             tmo_err_q, tmo_err_d;

  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    grant_inc;
  logic [TMO_W-1:0] cnt_inc;
  logic             own_ready;
  logic             accept;
  logic             stalled;
  logic [7:0]       own_byte;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned   cand;
    logic [GW-1:0] sel;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    sel        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      sel = GW'(cand);
      if (!pick_found && bus.req_valid[sel]) begin
        pick_found = 1'b1;
        pick_idx   = sel;
      end
    end
  end

  assign grant_inc = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign own_ready = ~tx_valid_q | bus.tx_ready;
  assign accept    = (state_q == StLocked) & own_ready & bus.req_valid[grant_q];
  // A transmitter-side stall is not charged to the owner.
  assign stalled   = tx_valid_q & ~bus.tx_ready;
  assign own_byte  = bus.req_bits[{grant_q, 3'b000} +: 8];

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StLocked && own_ready) bus.req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tmo_err_d  = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_bits_d  = tx_bits_q;

    // One-entry output buffer: drain and refill in the same cycle keeps 1 byte/cycle.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_bits_d  = own_byte;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.en && pick_found) begin
          state_d = StLocked;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      StLocked: begin
        if (accept) begin
          cnt_d = '0;
          if (bus.req_last[grant_q]) begin
            state_d = StIdle;
            ptr_d   = grant_inc;
          end
        end else if (!stalled) begin
          cnt_d = cnt_inc;
          if (bus.tmo_cycles != '0 && cnt_inc == bus.tmo_cycles) begin
            state_d   = StIdle;
            ptr_d     = grant_inc;
            tmo_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_bits_q  <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_bits_q  <= tx_bits_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_bits  = tx_bits_q;
  assign bus.locked   = (state_q == StLocked);
  assign bus.grant_id = grant_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_sirv_uarttx_arb.sv
// Bench for sirv_uarttx_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a cycle-level behavioural model.
module tb_sirv_uarttx_arb;
  localparam int N  = 4;
  localparam int GW = 2;
  localparam int TW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sirv_uarttx_arb_if #(.N_REQ(N), .GW(GW), .TMO_W(TW)) bus ();

  sirv_uarttx_arb #(.N_REQ(N), .GW(GW), .TMO_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner, pointer, idle-cycle count and the one-byte output buffer.
  bit m_locked, m_txv, m_err;
  int m_grant, m_ptr, m_idle, m_txb;

  function automatic void m_reset();
    m_locked = 0; m_txv = 0; m_err = 0;
    m_grant  = 0; m_ptr = 0; m_idle = 0; m_txb = 0;
  endfunction

  initial begin
    bit n_locked, n_txv, n_err, ready, acc, found;
    int n_grant, n_ptr, n_idle, n_txb, rv, rl, sel, exp_rr;
    m_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) m_reset();
      rv     = int'(bus.req_valid);
      rl     = int'(bus.req_last);
      ready  = m_locked && (!m_txv || bus.tx_ready);
      exp_rr = ready ? (1 << m_grant) : 0;
      chk("mdl_req_ready", 32'(bus.req_ready), 32'(exp_rr));
      chk("mdl_tx_valid",  32'(bus.tx_valid),  32'(m_txv));
      chk("mdl_tx_bits",   32'(bus.tx_bits),   32'(m_txb));
      chk("mdl_locked",    32'(bus.locked),    32'(m_locked));
      chk("mdl_grant_id",  32'(bus.grant_id),  32'(m_grant));
      chk("mdl_tmo_err",   32'(bus.tmo_err),   32'(m_err));

      acc = ready && (((rv >> m_grant) & 1) == 1);
      n_locked = m_locked; n_grant = m_grant; n_ptr = m_ptr; n_idle = m_idle;
      n_txv = m_txv; n_txb = m_txb; n_err = 0;
      if (acc) begin
        n_txv = 1;
        n_txb = int'(bus.req_bits >> (8 * m_grant)) & 255;
      end else if (m_txv && bus.tx_ready) begin
        n_txv = 0;
      end
      if (!m_locked) begin
        if (bus.en && rv != 0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            sel = (m_ptr + k) % N;
            if (!found && ((rv >> sel) & 1) == 1) begin
              found = 1;
              n_grant = sel;
            end
          end
          n_locked = 1;
          n_idle   = 0;
        end
      end else if (acc) begin
        n_idle = 0;
        if (((rl >> m_grant) & 1) == 1) begin
          n_locked = 0;
          n_ptr    = (m_grant + 1) % N;
        end
      end else if (!(m_txv && !bus.tx_ready)) begin
        n_idle = (m_idle < 255) ? m_idle + 1 : 255;
        if (bus.tmo_cycles != 0 && n_idle == int'(bus.tmo_cycles)) begin
          n_locked = 0;
          n_ptr    = (m_grant + 1) % N;
          n_err    = 1;
        end
      end
      @(posedge clk);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_locked = n_locked; m_grant = n_grant; m_ptr = n_ptr; m_idle = n_idle;
        m_txv = n_txv; m_txb = n_txb; m_err = n_err;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_byte(input int i, input int b);
    bus.req_bits[8*i +: 8] = 8'(b);
  endtask

  task automatic clear_inputs();
    bus.en = 1'b1; bus.tmo_cycles = '0; bus.req_valid = '0;
    bus.req_bits = '0; bus.req_last = '0; bus.tx_ready = 1'b1;
  endtask

  // Ends on a negedge with reset released and inputs idle.
  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input logic want, input string name);
    int w = 0;
    while (bus.locked !== want && w < 8) begin
      step();
      #1;
      w++;
    end
    chk(name, 32'(bus.locked), 32'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit seen_err;
    clear_inputs();
    bus.en = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_locked",    32'(bus.locked),    0);
    chk("rst_tx_valid",  32'(bus.tx_valid),  0);
    chk("rst_tx_bits",   32'(bus.tx_bits),   0);
    chk("rst_grant",     32'(bus.grant_id),  0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_tmo_err",   32'(bus.tmo_err),   0);

    // Two-byte message from requester 0.
    do_reset();
    bus.req_valid = 4'b0001; set_byte(0, 'h41);
    #1 chk("t1_idle_no_ready", 32'(bus.req_ready), 0);
    step(); #1;
    chk("t1_locked", 32'(bus.locked), 1);
    chk("t1_grant0", 32'(bus.grant_id), 0);
    chk("t1_ready0", 32'(bus.req_ready), 32'h1);
    step(); set_byte(0, 'h42); bus.req_last = 4'b0001; #1;
    chk("t1_tx41_valid", 32'(bus.tx_valid), 1);
    chk("t1_tx41", 32'(bus.tx_bits), 32'h41);
    step(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t1_tx42", 32'(bus.tx_bits), 32'h42);
    chk("t1_unlocked", 32'(bus.locked), 0);
    step(); #1;
    chk("t1_drained", 32'(bus.tx_valid), 0);

    // All four requesting single-byte messages: round-robin order with wrap.
    do_reset();
    bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
    for (int i = 0; i < N; i++) set_byte(i, 'h10 + 'h11 * i);
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_lock(1'b1, "t2_lock");
      chk("t2_grant_order", 32'(bus.grant_id), 32'(k % N));
      wait_lock(1'b0, "t2_release");
    end
    step(); bus.req_valid = '0; bus.req_last = '0;

    // Requester 1 mid-message must not be interleaved with requester 2.
    do_reset();
    bus.req_valid = 4'b0010; set_byte(1, 'hB0);
    step(); #1;
    chk("t3_grant1", 32'(bus.grant_id), 1);
    for (int j = 0; j < 4; j++) begin
      step(); bus.req_valid = 4'b0110; set_byte(1, 'hB1 + j); set_byte(2, 'hC0); #1;
      chk("t3_no_ready2", 32'(bus.req_ready & 4'b0100), 0);
      chk("t3_hold1", 32'(bus.grant_id), 1);
    end
    step(); bus.req_last = 4'b0010; #1;
    step(); bus.req_last = '0; bus.req_valid = 4'b0100; #1;
    chk("t3_released", 32'(bus.locked), 0);
    step(); #1;
    chk("t3_grant2", 32'(bus.grant_id), 2);
    chk("t3_ready2", 32'(bus.req_ready), 32'h4);
    step(); bus.req_valid = '0;

    // Transmitter stall: buffered byte held, owner not timed out.
    do_reset();
    bus.tmo_cycles = 8'd3; bus.tx_ready = 1'b0;
    bus.req_valid = 4'b0001; set_byte(0, 'h55);
    step(); step(); #1;
    chk("t4_valid", 32'(bus.tx_valid), 1);
    for (int j = 0; j < 5; j++) begin
      step(); #1;
      chk("t4_bits_stable", 32'(bus.tx_bits), 32'h55);
      chk("t4_no_ready", 32'(bus.req_ready), 0);
      chk("t4_no_tmo", 32'(bus.tmo_err), 0);
    end
    step(); bus.tx_ready = 1'b1; bus.req_valid = '0;

    // Watchdog release after 3 idle cycles, then next requester is granted.
    do_reset();
    bus.tmo_cycles = 8'd3; bus.req_valid = 4'b0011; set_byte(0, 'hA0);
    step(); #1;
    chk("t5_grant0", 32'(bus.grant_id), 0);
    step(); bus.req_valid = 4'b0010; #1;
    chk("t5_txA0", 32'(bus.tx_bits), 32'hA0);
    for (int j = 0; j < 2; j++) begin
      step(); #1;
      chk("t5_wait_tmo", 32'(bus.tmo_err), 0);
      chk("t5_still_locked", 32'(bus.locked), 1);
    end
    step(); #1;
    chk("t5_tmo_pulse", 32'(bus.tmo_err), 1);
    chk("t5_released", 32'(bus.locked), 0);
    step(); #1;
    chk("t5_tmo_one_cycle", 32'(bus.tmo_err), 0);
    chk("t5_grant1", 32'(bus.grant_id), 1);
    chk("t5_relocked", 32'(bus.locked), 1);

    // Same stimulus with the watchdog disabled: lock is held.
    do_reset();
    bus.req_valid = 4'b0011; set_byte(0, 'hA0);
    step(); step(); bus.req_valid = 4'b0010;
    seen_err = 0;
    for (int j = 0; j < 20; j++) begin
      step(); #1;
      if (bus.tmo_err) seen_err = 1;
    end
    chk("t5b_no_tmo", 32'(seen_err), 0);
    chk("t5b_locked", 32'(bus.locked), 1);
    chk("t5b_grant0", 32'(bus.grant_id), 0);

    // Reset mid-message with a buffered byte; pointer must return to 0.
    do_reset();
    bus.req_valid = 4'b0010; bus.req_last = 4'b0010; set_byte(1, 'hC1);
    step(); #1;
    step(); bus.req_valid = 4'b0100; bus.req_last = '0; set_byte(2, 'hC2); #1;
    step(); #1;
    chk("t6_grant2", 32'(bus.grant_id), 2);
    step(); bus.tx_ready = 1'b0; #1;
    chk("t6_buffered", 32'(bus.tx_bits), 32'hC2);
    step(); rst_n = 1'b0; #1;
    chk("t6_rst_valid", 32'(bus.tx_valid), 0);
    chk("t6_rst_bits",  32'(bus.tx_bits), 0);
    chk("t6_rst_lock",  32'(bus.locked), 0);
    chk("t6_rst_grant", 32'(bus.grant_id), 0);
    chk("t6_rst_ready", 32'(bus.req_ready), 0);
    step(); rst_n = 1'b1; bus.req_valid = 4'b1111; bus.tx_ready = 1'b1;
    step(); #1;
    chk("t6_ptr_reset", 32'(bus.grant_id), 0);

    // Randomized traffic; the model checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n         = ($urandom_range(499) != 0);
      bus.en        = ($urandom_range(15) != 0);
      bus.req_valid = 4'($urandom);
      bus.req_bits  = $urandom;
      bus.req_last  = '0;
      for (int i = 0; i < N; i++) bus.req_last[i] = ($urandom_range(3) == 0);
      bus.tx_ready  = ($urandom_range(3) != 0);
      if (c % 200 == 0) begin
        case ($urandom_range(4))
          0: bus.tmo_cycles = 8'd0;
          1: bus.tmo_cycles = 8'd1;
          2: bus.tmo_cycles = 8'd2;
          3: bus.tmo_cycles = 8'd4;
          default: bus.tmo_cycles = 8'd7;
        endcase
      end
    end
    step();
    rst_n = 1'b1;
    clear_inputs();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
